// File: rtl/time_counter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | time_counter_if                                                       |
// | Control and status bundle for the stopwatch timer.                    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface time_counter_if;
  logic        start;
  logic        stop;
  logic [1:0]  min_counter;
  logic        clk_1Hz;
  logic        done;
  logic [7:0]  count;
  logic [26:0] counter;

  modport master (
    output start, stop,
    input  min_counter, clk_1Hz, done, count, counter
  );

  modport slave (
    input  start, stop,
    output min_counter, clk_1Hz, done, count, counter
  );
endinterface
`default_nettype wire

// File: rtl/time_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | time_counter                                                          |
// | Stopwatch: divides clk to a 1 s tick, counts seconds and minutes.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module time_counter #(
  parameter int CLK_HZ    = 125_000_000,
  parameter int SEC_MAX   = 59,
  parameter int MIN_LIMIT = 3
) (
  input  wire logic     clk_125MHz,
  input  wire logic     rst,
  time_counter_if.slave bus
);

  localparam logic [26:0] c_cnt_top   = 27'(CLK_HZ - 1);
  localparam logic [26:0] c_cnt_half  = 27'(CLK_HZ / 2 - 1);
  localparam logic [7:0]  c_sec_max   = 8'(SEC_MAX);
  localparam logic [1:0]  c_min_limit = 2'(MIN_LIMIT);

  logic        start_q,   start_d;
  logic        run_q,     run_d;
  logic [26:0] counter_q, counter_d;
  logic        clk_1hz_q, clk_1hz_d;
  logic [7:0]  count_q,   count_d;
  logic [1:0]  min_q,     min_d;
  logic        done_q,    done_d;

  logic w_start_edge;
  logic w_advance;

  assign w_start_edge = bus.start & ~start_q;
  assign w_advance    = run_q & ~done_q;

  always_comb begin
    start_d   = bus.start;
    run_d     = run_q;
    counter_d = counter_q;
    clk_1hz_d = clk_1hz_q;
    count_d   = count_q;
    min_d     = min_q;
    done_d    = done_q;

    if (w_start_edge && !bus.stop) begin
      counter_d = '0;
      clk_1hz_d = 1'b0;
      count_d   = '0;
      min_d     = '0;
      done_d    = 1'b0;
      run_d     = 1'b1;
    end else begin
      if (w_advance) begin
        if (counter_q == c_cnt_top) begin
          counter_d = '0;
          clk_1hz_d = 1'b0;
          if (count_q == c_sec_max) begin
            count_d = '0;
            min_d   = min_q + 2'd1;
            // Reaching the limit freezes the divider at 0 in the same clock.
            if (min_d == c_min_limit) begin
              done_d = 1'b1;
              run_d  = 1'b0;
            end
          end else begin
            count_d = count_q + 8'd1;
          end
        end else begin
          counter_d = counter_q + 27'd1;
          if (counter_q == c_cnt_half) begin
            clk_1hz_d = 1'b1;
          end
        end
      end
      if (bus.stop) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_125MHz or posedge rst) begin
    if (rst) begin
      start_q   <= 1'b0;
      run_q     <= 1'b0;
      counter_q <= '0;
      clk_1hz_q <= 1'b0;
      count_q   <= '0;
      min_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      start_q   <= start_d;
      run_q     <= run_d;
      counter_q <= counter_d;
      clk_1hz_q <= clk_1hz_d;
      count_q   <= count_d;
      min_q     <= min_d;
      done_q    <= done_d;
    end
  end

  assign bus.counter     = counter_q;
  assign bus.clk_1Hz     = clk_1hz_q;
  assign bus.count       = count_q;
  assign bus.min_counter = min_q;
  assign bus.done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_time_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_time_counter                                                       |
// | Checks a 10 Hz and a 125 MHz stopwatch against an elapsed-time model. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_time_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st  = 1'b1;
  logic sp  = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_counter_if u_if0 ();
  time_counter_if u_if1 ();

  assign u_if0.start = st;
  assign u_if0.stop  = sp;
  assign u_if1.start = st;
  assign u_if1.stop  = sp;

  time_counter #(.CLK_HZ(10)) u_dut0 (
    .clk_125MHz (clk),
    .rst        (rst),
    .bus        (u_if0.slave)
  );

  time_counter u_dut1 (
    .clk_125MHz (clk),
    .rst        (rst),
    .bus        (u_if1.slave)
  );

  // Model: total run cycles since the last restart; every output is derived from it.
  longint el [2];
  bit     rn [2];
  bit     ps;
  longint hz [2] = '{64'd10, 64'd125_000_000};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      el[i] = 0;
      rn[i] = 1'b0;
    end
    ps = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit p);
    bit edge_s;
    edge_s = s & ~ps;
    for (int i = 0; i < 2; i++) begin
      longint lim;
      lim = 180 * hz[i];
      if (edge_s && !p) begin
        el[i] = 0;
        rn[i] = 1'b1;
      end else begin
        if (rn[i] && el[i] < lim) el[i]++;
        if (p || el[i] >= lim) rn[i] = 1'b0;
      end
    end
    ps = s;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint e_counter(int i); return el[i] % hz[i]; endfunction
  function automatic longint e_count(int i);   return (el[i] / hz[i]) % 60; endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      longint secs;
      secs = el[i] / hz[i];
      if (i == 0) begin
        chk("counter0", 64'(u_if0.counter),     64'(e_counter(0)));
        chk("count0",   64'(u_if0.count),       64'(e_count(0)));
        chk("min0",     64'(u_if0.min_counter), 64'(secs / 60));
        chk("clk1hz0",  64'(u_if0.clk_1Hz),     64'(e_counter(0) >= hz[0] / 2));
        chk("done0",    64'(u_if0.done),        64'(el[0] >= 180 * hz[0]));
      end else begin
        chk("counter1", 64'(u_if1.counter),     64'(e_counter(1)));
        chk("count1",   64'(u_if1.count),       64'(e_count(1)));
        chk("clk1hz1",  64'(u_if1.clk_1Hz),     64'(e_counter(1) >= hz[1] / 2));
        chk("done1",    64'(u_if1.done),        64'(el[1] >= 180 * hz[1]));
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(st, sp);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit reached;
    model_reset();

    // Reset with start held, then release: start counts as an edge.
    repeat (20) cyc();
    rst = 1'b0;
    repeat (12) cyc();

    // Roll over into the first minute.
    repeat (600) cyc();

    // Restart, stop at counter=6/count=12, freeze, then restart.
    st = 1'b0; cyc();
    st = 1'b1; cyc();
    reached = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (e_counter(0) == 5 && e_count(0) == 12) begin
        reached = 1'b1;
        break;
      end
      cyc();
    end
    chk("reach_stop_point", 64'(reached), 64'd1);
    sp = 1'b1;
    repeat (50) cyc();
    chk("frozen_counter", 64'(u_if0.counter), 64'd6);
    chk("frozen_count",   64'(u_if0.count),   64'd12);
    sp = 1'b0; cyc();
    st = 1'b0; cyc();
    st = 1'b1; cyc();
    chk("restart_counter", 64'(u_if0.counter), 64'd0);
    chk("restart_count",   64'(u_if0.count),   64'd0);

    // Run to the minute limit, hold start, then re-edge.
    repeat (1805) cyc();
    chk("done_reached", 64'(u_if0.done),        64'd1);
    chk("done_min",     64'(u_if0.min_counter), 64'd3);
    repeat (20) cyc();
    st = 1'b0; cyc();
    st = 1'b1; repeat (20) cyc();
    chk("done_cleared", 64'(u_if0.done), 64'd0);

    // Randomized start/stop activity.
    repeat (1500) begin
      if ($urandom % 40 == 0) st = ~st;
      if ($urandom % 50 == 0) sp = 1'b1;
      else if ($urandom % 4 == 0) sp = 1'b0;
      cyc();
    end

    // Asynchronous reset between edges.
    sp = 1'b0;
    st = 1'b0; cyc();
    st = 1'b1; repeat (37) cyc();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (3) cyc();
    rst = 1'b0;
    st = 1'b0; cyc();
    st = 1'b1; repeat (30) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
